// File: rtl/fic2_apb_gpio_in.sv
// APB3 completer for the fabric-to-MSS GPIO path: input synchroniser, edge detect,
// W1C interrupt status and a single masked level interrupt, with fixed wait states.
module fic2_apb_gpio_in #(
   parameter int unsigned GPIO_WIDTH  = 8,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = 32'h4750_4901
) (
   input  logic                  PCLK,
   input  logic                  PRESET,
   input  logic                  PSEL,
   input  logic                  PENABLE,
   input  logic                  PWRITE,
   input  logic [7:2]            PADDR,
   input  logic [31:0]           PWDATA,
   output logic [31:0]           PRDATA,
   output logic                  PREADY,
   output logic                  PSLVERR,
   input  logic [GPIO_WIDTH-1:0] GPIO_IN,
   output logic                  IRQ
);

   localparam int unsigned GW    = GPIO_WIDTH;
   localparam int unsigned CNT_W = 2;
   localparam logic [CNT_W-1:0] CNT_LOAD =
      (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;

   localparam logic [5:0] A_DATA    = 6'h00;
   localparam logic [5:0] A_RISE_EN = 6'h01;
   localparam logic [5:0] A_FALL_EN = 6'h02;
   localparam logic [5:0] A_IRQ_EN  = 6'h03;
   localparam logic [5:0] A_STATUS  = 6'h04;
   localparam logic [5:0] A_ID      = 6'h05;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             pready_q;
   logic             pslverr_q;
   logic [31:0]      prdata_q;
   logic             irq_q;

   logic [GW-1:0] sync1_q, sync2_q, prev_q;
   logic [GW-1:0] rise_en_q, fall_en_q, irq_en_q;
   logic [GW-1:0] status_q, status_d;
   logic [GW-1:0] rise, fall, clr;

   logic        access;
   logic        enter_done;
   logic        wr_commit;
   logic        addr_ok;
   logic [31:0] rdata;
   logic        unused_pwdata;

   assign access        = PSEL & PENABLE;
   assign wr_commit     = (state_q == S_DONE) & PSEL & PENABLE & PWRITE;
   assign enter_done    = ((state_q == S_IDLE) && access && (WAIT_STATES == 0)) ||
                          ((state_q == S_WAIT) && PSEL && (cnt_q == '0));
   assign unused_pwdata = ^PWDATA;

   // Read mux and address decode
   always_comb begin
      rdata   = '0;
      addr_ok = 1'b1;
      case (PADDR)
         A_DATA:    rdata = 32'(sync2_q);
         A_RISE_EN: rdata = 32'(rise_en_q);
         A_FALL_EN: rdata = 32'(fall_en_q);
         A_IRQ_EN:  rdata = 32'(irq_en_q);
         A_STATUS:  rdata = 32'(status_q);
         A_ID:      rdata = ID_VALUE;
         default:   addr_ok = 1'b0;
      endcase
   end

   // Edge detect and W1C status; a new event beats a same-cycle clear
   always_comb begin
      rise     = sync2_q & ~prev_q & rise_en_q;
      fall     = ~sync2_q & prev_q & fall_en_q;
      clr      = (wr_commit && (PADDR == A_STATUS)) ? PWDATA[GW-1:0] : '0;
      status_d = (status_q & ~clr) | rise | fall;
   end

   // Transfer FSM with registered response
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         pready_q  <= enter_done;
         pslverr_q <= enter_done & ~addr_ok;
         prdata_q  <= enter_done ? rdata : '0;
         case (state_q)
            S_IDLE: begin
               if (access) begin
                  if (WAIT_STATES > 0) begin
                     state_q <= S_WAIT;
                     cnt_q   <= CNT_LOAD;
                  end else begin
                     state_q <= S_DONE;
                  end
               end
            end
            S_WAIT: begin
               if (!PSEL) begin
                  state_q <= S_IDLE;
               end else if (cnt_q == '0) begin
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Synchroniser, control registers, status and interrupt
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         irq_en_q  <= '0;
         status_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         sync1_q  <= GPIO_IN;
         sync2_q  <= sync1_q;
         prev_q   <= sync2_q;
         status_q <= status_d;
         irq_q    <= |(status_q & irq_en_q);
         if (wr_commit) begin
            case (PADDR)
               A_RISE_EN: rise_en_q <= PWDATA[GW-1:0];
               A_FALL_EN: fall_en_q <= PWDATA[GW-1:0];
               A_IRQ_EN:  irq_en_q  <= PWDATA[GW-1:0];
               default: ;
            endcase
         end
      end
   end

   assign PRDATA  = prdata_q;
   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;
   assign IRQ     = irq_q;

endmodule
